// File: rtl/ddr_bus_turnaround_ctrl.sv
// DQ/DQS direction control for a DDR data bus: sequences write preamble/burst/postamble/recovery
// and read latency/capture/turnaround, rejecting any command that arrives while a sequence runs.
module ddr_bus_turnaround_ctrl #(
    parameter int unsigned LANES = 2,
    parameter int unsigned BL    = 4,
    parameter int unsigned WL    = 1,
    parameter int unsigned CL    = 3,
    parameter int unsigned TWR   = 3,
    parameter int unsigned TRTW  = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_cmd_i,
    input  logic             rd_cmd_i,
    input  logic [LANES-1:0] lane_mask_i,
    output logic [LANES-1:0] dq_oe_o,
    output logic [LANES-1:0] dqs_oe_o,
    output logic             rd_capture_o,
    output logic             busy_o,
    output logic             cmd_err_o
);

    localparam int unsigned BurstCyc = BL / 2;

    // Counters count down to zero, so each phase loads its length minus one.
    localparam logic [CNT_W-1:0] WlLoad    = CNT_W'(WL - 1);
    localparam logic [CNT_W-1:0] ClLoad    = CNT_W'(CL - 1);
    localparam logic [CNT_W-1:0] BurstLoad = CNT_W'(BurstCyc - 1);
    localparam logic [CNT_W-1:0] TwrLoad   = CNT_W'(TWR - 1);
    localparam logic [CNT_W-1:0] TrtwLoad  = CNT_W'((TRTW > 0) ? TRTW - 1 : 0);

    typedef enum logic [3:0] {
        StIdle,
        StWrLat,
        StWrPre,
        StWrBurst,
        StWrPost,
        StWrRecov,
        StRdLat,
        StRdBurst,
        StRdTurn
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LANES-1:0] mask_q, mask_d;

    logic [LANES-1:0] dq_oe_d, dqs_oe_d;
    logic             rd_capture_d, busy_d, cmd_err_d;

    logic cnt_zero;
    logic wr_only, rd_only, any_cmd;

    assign cnt_zero = (cnt_q == '0);
    assign wr_only  = wr_cmd_i & ~rd_cmd_i;
    assign rd_only  = rd_cmd_i & ~wr_cmd_i;
    assign any_cmd  = wr_cmd_i | rd_cmd_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;

        unique case (state_q)
            StIdle: begin
                if (wr_only) begin
                    state_d = StWrLat;
                    cnt_d   = WlLoad;
                    mask_d  = lane_mask_i;
                end else if (rd_only) begin
                    state_d = StRdLat;
                    cnt_d   = ClLoad;
                    mask_d  = '0;
                end
            end
            StWrLat: begin
                if (cnt_zero) begin
                    state_d = StWrPre;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StWrPre: begin
                state_d = StWrBurst;
                cnt_d   = BurstLoad;
            end
            StWrBurst: begin
                if (cnt_zero) begin
                    state_d = StWrPost;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StWrPost: begin
                state_d = StWrRecov;
                cnt_d   = TwrLoad;
            end
            StWrRecov: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                    mask_d  = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRdLat: begin
                if (cnt_zero) begin
                    state_d = StRdBurst;
                    cnt_d   = BurstLoad;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRdBurst: begin
                if (cnt_zero) begin
                    if (TRTW == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StRdTurn;
                        cnt_d   = TrtwLoad;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StRdTurn: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                mask_d  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        dqs_oe_d     = '0;
        dq_oe_d      = '0;
        rd_capture_d = 1'b0;
        busy_d       = (state_d != StIdle);
        cmd_err_d    = any_cmd & ((state_q != StIdle) | (wr_cmd_i & rd_cmd_i));

        unique case (state_d)
            StWrPre: begin
                dqs_oe_d = mask_d;
            end
            StWrBurst, StWrPost: begin
                dqs_oe_d = mask_d;
                dq_oe_d  = mask_d;
            end
            StWrRecov: begin
                dq_oe_d = mask_d;
            end
            StRdBurst: begin
                rd_capture_d = 1'b1;
            end
            default: begin
                dqs_oe_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            mask_q       <= '0;
            dq_oe_o      <= '0;
            dqs_oe_o     <= '0;
            rd_capture_o <= 1'b0;
            busy_o       <= 1'b0;
            cmd_err_o    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            dq_oe_o      <= dq_oe_d;
            dqs_oe_o     <= dqs_oe_d;
            rd_capture_o <= rd_capture_d;
            busy_o       <= busy_d;
            cmd_err_o    <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_ddr_bus_turnaround_ctrl.sv
// Bench for ddr_bus_turnaround_ctrl: directed and random commands checked against a model that
// predicts each output from the cycle offset since the last accepted command.
module tb_ddr_bus_turnaround_ctrl;

    localparam int LANES = 2;
    localparam int BL    = 4;
    localparam int WL    = 1;
    localparam int CL    = 3;
    localparam int TWR   = 3;
    localparam int TRTW  = 2;

    logic             clk;
    logic             rst_ni;
    logic             wr_cmd;
    logic             rd_cmd;
    logic [LANES-1:0] lane_mask;
    logic [LANES-1:0] dq_oe;
    logic [LANES-1:0] dqs_oe;
    logic             rd_capture;
    logic             busy;
    logic             cmd_err;

    int total = 0;
    int bad   = 0;

    // Model state: one transaction described by its accept edge, kind, length and mask.
    int               edge_n   = 0;
    int               t0       = 0;
    int               dur      = 0;
    bit               have_txn = 0;
    bit               is_wr    = 0;
    logic [LANES-1:0] tmask    = '0;
    logic             exp_err  = 0;

    ddr_bus_turnaround_ctrl #(
        .LANES (LANES),
        .BL    (BL),
        .WL    (WL),
        .CL    (CL),
        .TWR   (TWR),
        .TRTW  (TRTW),
        .CNT_W (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .wr_cmd_i     (wr_cmd),
        .rd_cmd_i     (rd_cmd),
        .lane_mask_i  (lane_mask),
        .dq_oe_o      (dq_oe),
        .dqs_oe_o     (dqs_oe),
        .rd_capture_o (rd_capture),
        .busy_o       (busy),
        .cmd_err_o    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".dq_oe"}, 32'(dq_oe), 32'd0);
        chk({tag, ".dqs_oe"}, 32'(dqs_oe), 32'd0);
        chk({tag, ".rd_capture"}, 32'(rd_capture), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".cmd_err"}, 32'(cmd_err), 32'd0);
    endtask

    // Apply inputs for one edge, advance the model, then check outputs on the falling edge.
    task automatic tick(input logic wr, input logic rd, input logic [LANES-1:0] mask);
        int               k;
        bit               free;
        logic [LANES-1:0] e_dq, e_dqs;
        logic             e_cap, e_busy;
        wr_cmd    = wr;
        rd_cmd    = rd;
        lane_mask = mask;
        @(posedge clk);
        edge_n++;
        free    = !have_txn || (edge_n > t0 + dur);
        exp_err = (wr | rd) && (!free || (wr && rd));
        if (free && (wr ^ rd)) begin
            have_txn = 1;
            is_wr    = wr;
            t0       = edge_n;
            tmask    = mask;
            dur      = wr ? (WL + 2 + BL / 2 + TWR) : (CL + BL / 2 + TRTW);
        end
        @(negedge clk);
        k      = edge_n - t0;
        e_dq   = '0;
        e_dqs  = '0;
        e_cap  = 0;
        e_busy = 0;
        if (have_txn && k < dur) begin
            e_busy = 1;
            if (is_wr) begin
                if (k >= WL && k < WL + 2 + BL / 2) e_dqs = tmask;
                if (k >= WL + 1) e_dq = tmask;
            end else begin
                e_cap = (k >= CL && k < CL + BL / 2);
            end
        end
        chk("dq_oe", 32'(dq_oe), 32'(e_dq));
        chk("dqs_oe", 32'(dqs_oe), 32'(e_dqs));
        chk("rd_capture", 32'(rd_capture), 32'(e_cap));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("cmd_err", 32'(cmd_err), 32'(exp_err));
        chk("no_drive_in_capture", 32'(rd_capture && ((dq_oe | dqs_oe) != '0)), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, LANES'($urandom));
    endtask

    initial begin
        wr_cmd    = 0;
        rd_cmd    = 0;
        lane_mask = '0;
        rst_ni    = 1'b1;
        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_ni = 1'b1;

        // Full-mask write, then read
        tick(1'b1, 1'b0, 2'b11);
        idle(10);
        tick(1'b0, 1'b1, 2'b00);
        idle(9);

        // Read with a write arriving mid-sequence
        tick(1'b0, 1'b1, 2'b00);
        idle(1);
        tick(1'b1, 1'b0, 2'b11);
        idle(8);

        // Simultaneous commands in idle
        tick(1'b1, 1'b1, 2'b11);
        idle(2);

        // Single-lane write with mask churn, then an all-zero mask write
        tick(1'b1, 1'b0, 2'b01);
        idle(9);
        tick(1'b1, 1'b0, 2'b00);
        idle(9);

        // Command held high continuously: exercises rejection on the busy-falling edge
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 2'b10);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 2'b00);
        idle(8);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 11);
            tick(r == 0 || r == 2, r == 1 || r == 2, LANES'($urandom));
        end
        idle(10);

        // Reset in the middle of a write, then a read straight after release
        tick(1'b1, 1'b0, 2'b11);
        idle(3);
        rst_ni = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        have_txn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("held_reset");
        rst_ni = 1'b1;
        tick(1'b0, 1'b1, 2'b11);
        idle(9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
